// File: rtl/logic_wb_stage.sv
// Writeback/flag stage after the logic unit: result FIFO toward the register file,
// architectural flag register and branch-condition evaluation. Optional stall counter: LOGIC_WB_STALL_CNT_EN.
module logic_wb_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [4:0]       in_flags,
  input  logic [AW-1:0]    in_dest,
  input  logic             in_setflags,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [WIDTH-1:0] wb_data,
  output logic [AW-1:0]    wb_dest,
  output logic [4:0]       flags_q,
  input  logic [2:0]       cond_sel,
  output logic             cond_true,
  output logic [15:0]      stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Ready never depends combinationally on the other side's valid/ready; a producer
  // that sees ready=0 holds its data until it is accepted.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [AW-1:0]    dest_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             accept;
  logic             pop;

  assign in_ready = (count != FULL_CNT);
  assign wb_valid = (count != '0);
  assign accept   = in_valid & in_ready;
  assign pop      = wb_valid & wb_ready;

  // Outputs are forced to zero while empty so stale entries never show.
  assign wb_data  = wb_valid ? data_mem[rd_ptr] : '0;
  assign wb_dest  = wb_valid ? dest_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        dest_mem[i] <= '0;
      end
    end else if (accept) begin
      data_mem[wr_ptr] <= in_result;
      dest_mem[wr_ptr] <= in_dest;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flags update at accept time, independent of when the result is written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 5'b00000;
    end else if (accept && in_setflags) begin
      flags_q <= in_flags;
    end
  end

  logic flag_za;
  logic flag_eq;
  logic flag_gt;
  logic flag_lt;

  assign flag_za = flags_q[4];
  assign flag_eq = flags_q[2];
  assign flag_gt = flags_q[1];
  assign flag_lt = flags_q[0];

  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flag_eq;
      3'd2:    cond_true = ~flag_eq;
      3'd3:    cond_true = flag_gt;
      3'd4:    cond_true = flag_lt;
      3'd5:    cond_true = flag_gt | flag_eq;
      3'd6:    cond_true = flag_lt | flag_eq;
      default: cond_true = flag_za;
    endcase
  end

`ifdef LOGIC_WB_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of cycles the register file holds off a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if (wb_valid && !wb_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
